// File: rtl/cpu_pkg.sv
// Shared opcodes, instruction field positions, ALU operation and FSM state types
// for the multi-cycle cpu_core.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam int OPC_LSB  = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;
  localparam int IMM_LSB  = 0;
  localparam int OFF_LSB  = 16;

  typedef enum logic [2:0] {
    PASS_IMM,
    PASS_B,
    ADD,
    AND,
    OR
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational DATA_W-bit ALU; sub_i turns ADD into a two's-complement subtract.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op_i,
  input  logic              sub_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W-1:0] b_eff;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    y_o   = '0;
    b_eff = sub_i ? (~b_i + DATA_W'(1)) : b_i;
    unique case (op_i)
      PASS_IMM: y_o = imm_i;
      PASS_B:   y_o = b_i;
      ADD:      y_o = a_i + b_eff;
      AND:      y_o = a_i & b_i;
      OR:       y_o = a_i | b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle FETCH/EXEC/HALT core with register file, decode and PC.
// Define CPU_BRANCH_EN to decode 0x06/0x07 as j/beq; otherwise they trap as illegal.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 8,
  parameter int PC_W    = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic              illegal
);

  localparam int ADDR_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic              wb_en_q, wb_en_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              illegal_q, illegal_d;
  logic              reg_we;

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] dest_a, src1_a, src2_a;
  logic [DATA_W-1:0] rs1, rs2, imm_ext, alu_y;
  logic [PC_W-1:0]   pc_seq, pc_exec;
  alu_op_e           alu_op;
  logic              alu_sub, op_writes, op_illegal, op_halt;
  logic              unused_instr;

  assign opcode  = instr_q[OPC_LSB +: 8];
  assign dest_a  = instr_q[DEST_LSB +: ADDR_W];
  assign src1_a  = instr_q[SRC1_LSB +: ADDR_W];
  assign src2_a  = instr_q[SRC2_LSB +: ADDR_W];
  assign rs1     = regs_q[src1_a];
  assign rs2     = regs_q[src2_a];
  assign imm_ext = DATA_W'($signed(instr_q[IMM_LSB +: 8]));
  assign pc_seq  = pc_q + PC_W'(PC_STEP);
  // Field bits not decoded in every configuration are deliberately ignored.
  assign unused_instr = ^instr_q;

`ifdef CPU_BRANCH_EN
  logic [PC_W-1:0] br_target;
  logic            rs_equal;
  assign br_target = pc_seq + PC_W'($signed(instr_q[OFF_LSB +: 8])) * PC_W'(PC_STEP);
  assign rs_equal  = (rs1 == rs2);
`endif

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i  (alu_op),
    .sub_i (alu_sub),
    .a_i   (rs1),
    .b_i   (rs2),
    .imm_i (imm_ext),
    .y_o   (alu_y)
  );

  always_comb begin
    alu_op     = PASS_IMM;
    alu_sub    = 1'b0;
    op_writes  = 1'b0;
    op_illegal = 1'b0;
    op_halt    = 1'b0;
    pc_exec    = pc_seq;
    case (opcode)
      OP_LOADI: op_writes = 1'b1;
      OP_MOV:   begin alu_op = PASS_B; op_writes = 1'b1; end
      OP_ADD:   begin alu_op = ADD;    op_writes = 1'b1; end
      OP_SUB:   begin alu_op = ADD;    alu_sub = 1'b1; op_writes = 1'b1; end
      OP_AND:   begin alu_op = AND;    op_writes = 1'b1; end
      OP_OR:    begin alu_op = OR;     op_writes = 1'b1; end
`ifdef CPU_BRANCH_EN
      OP_J:     pc_exec = br_target;
      OP_BEQ:   if (rs_equal) pc_exec = br_target;
`endif
      OP_HALT:  begin op_halt = 1'b1; pc_exec = pc_q; end
      default:  op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    illegal_d = illegal_q;
    reg_we    = 1'b0;
    case (state_q)
      ST_FETCH: if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        pc_d    = pc_exec;
        state_d = op_halt ? ST_HALT : ST_FETCH;
        if (op_writes) begin
          reg_we    = 1'b1;
          wb_en_d   = 1'b1;
          wb_addr_d = 3'(dest_a);
          wb_data_d = alu_y;
        end
        if (op_illegal) illegal_d = 1'b1;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      illegal_q <= illegal_d;
      if (state_q == ST_FETCH && instr_valid) instr_q <= instruction;
    end
  end

  // NOTE: the register file is reset because software relies on every register reading 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[dest_a] <= alu_y;
    end
  end

  // Ready is gated by reset so it reads 0 while reset is held, even though the state is FETCH.
  assign instr_ready = (state_q == ST_FETCH) && rst;
  assign pc          = pc_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign halted      = (state_q == ST_HALT);
  assign illegal     = illegal_q;

endmodule
